wr_ptr_ctrl: RTL
================

WR_PTR_CTRL -- requirements
Module: wr_ptr_ctrl

Interface
REQ-001 SHALL have parameter Addr_width, default 5, memory address width; FIFO depth = 2**Addr_width; legal range 2..12.
REQ-002 SHALL have parameter AFULL_THRESH, default 28, fill level at or above which almost_full asserts; legal range 1..2**Addr_width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port Enable  input  1  write request from the producer.
REQ-006 SHALL have port rd_ptr_gray_sync  input  Addr_width+1  read pointer (Gray), already synchronised into clk domain.
REQ-007 SHALL have port wr_accept  output  1  combinational: Enable && !full; memory write strobe.
REQ-008 SHALL have port address  output  Addr_width  memory write address = wr_ptr_bin[Addr_width-1:0].
REQ-009 SHALL have port wr_ptr_bin  output  Addr_width+1  registered binary write pointer including wrap bit.
REQ-010 SHALL have port wr_ptr_gray  output  Addr_width+1  registered Gray write pointer for crossing to the read domain.
REQ-011 SHALL have port full  output  1  registered full flag.
REQ-012 SHALL have port level  output  Addr_width+1  registered fill count, 0..2**Addr_width.
REQ-013 SHALL have port almost_full  output  1  registered threshold flag (see REQ-027).
REQ-014 SHALL have port overflow  output  1  sticky error: write requested while full.

Function
REQ-015 A write SHALL be accepted in a cycle iff wr_accept=1; accepted write increments wr_ptr_bin by 1 at that clock edge.
REQ-016 Enable while full=1 SHALL be ignored: pointers unchanged, no memory strobe.
REQ-017 wr_ptr_bin SHALL wrap modulo 2**(Addr_width+1) (all-ones -> zero); wrap bit toggles every depth writes.
REQ-018 wr_ptr_gray SHALL equal bin2gray of wr_ptr_bin, updated on the same edge (registered from next binary value, no extra cycle of latency); only one bit changes per increment.
REQ-019 Next full SHALL be computed from next Gray pointer: full_next = (gray_next == {~rd_ptr_gray_sync[Addr_width:Addr_width-1], rd_ptr_gray_sync[Addr_width-2:0]}); registered.
REQ-020 full SHALL assert on the edge that accepts the write filling the last slot (visible the cycle after that write).
REQ-021 full SHALL deassert one cycle after rd_ptr_gray_sync changes to a value making REQ-019 false, regardless of Enable.
REQ-022 Internal rd binary SHALL be gray2bin(rd_ptr_gray_sync), combinational XOR-prefix conversion.
REQ-023 level_next SHALL be (bin_next - rd binary) modulo 2**(Addr_width+1); registered into level.
REQ-024 Simultaneous accepted write and read-pointer advance SHALL produce net level change of zero within that update.
REQ-025 overflow SHALL set on any cycle with Enable=1 and full=1; stays 1 until reset.
REQ-026 Read pointer values implying level > depth SHALL NOT corrupt the write pointer; full and level follow formula only.

Reset
REQ-027 (Also function) almost_full_next SHALL be (level_next >= AFULL_THRESH); registered.
REQ-028 rst=1 at a clock edge SHALL force wr_ptr_bin=0, wr_ptr_gray=0, full=0, level=0, almost_full=0, overflow=0.
REQ-029 Reset SHALL take priority over Enable; a write requested in a reset cycle is dropped.
REQ-030 wr_accept SHALL be 0 while full=0 is forced by reset only if Enable=0; no gating of wr_accept by rst beyond full.

Configuration
REQ-031 Macro WR_PTR_ALMOST_FULL_EN SHALL control almost-full logic.
REQ-032 With WR_PTR_ALMOST_FULL_EN defined: almost_full per REQ-027, AFULL_THRESH used.
REQ-033 Without it: almost_full tied to 0, comparator absent, AFULL_THRESH ignored; all other behaviour identical.

Verification (Addr_width=5, AFULL_THRESH=28, macro defined unless stated)
REQ-034 rst 1 cycle, rd_ptr_gray_sync=0, Enable=1 for 32 cycles -> wr_ptr_bin=6'h20, wr_ptr_gray=6'b110000, full=1, level=32 one cycle after 32nd accept; address ran 0..31.
REQ-035 From full, Enable=1 3 more cycles -> wr_accept=0, pointers unchanged, overflow=1 and stays 1 until rst.
REQ-036 From full, rd_ptr_gray_sync 0 -> 6'b000001 with Enable=0 -> next cycle full=0, level=31; then one write -> full=1, level=32.
REQ-037 Wrap: drive reads to keep space, write until wr_ptr_bin=63 then one write -> wr_ptr_bin=0, wr_ptr_gray 6'b100000 -> 6'b000000.
REQ-038 Fill from empty -> almost_full rises in same cycle level=28; macro undefined -> almost_full=0 throughout.
REQ-039 rst asserted mid-burst at level=10 with Enable=1 -> next cycle all outputs per REQ-028, writes resume from address 0 after release.

Source files
------------

// File: rtl/wr_ptr_ctrl.sv
// wr_ptr_ctrl: FIFO write-side pointer controller (binary/Gray pointers, full, level, almost_full, overflow)
//   clk, rst              : single clock, synchronous active-high reset
//   Enable                : producer write request
//   rd_ptr_gray_sync      : read pointer (Gray), already synchronised into clk
//   wr_accept             : combinational memory write strobe (Enable && !full)
//   address               : memory write address (low bits of wr_ptr_bin)
//   wr_ptr_bin/wr_ptr_gray: registered write pointer, binary and Gray, with wrap bit
//   full, level           : registered full flag and fill count 0..2**Addr_width
//   almost_full           : registered level >= AFULL_THRESH (only with WR_PTR_ALMOST_FULL_EN, else 0)
//   overflow              : sticky flag, write requested while full
// Optional feature macro: WR_PTR_ALMOST_FULL_EN
module wr_ptr_ctrl #(
    parameter int Addr_width   = 5,
    parameter int AFULL_THRESH = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Enable,
    input  logic [Addr_width:0]   rd_ptr_gray_sync,
    output logic                  wr_accept,
    output logic [Addr_width-1:0] address,
    output logic [Addr_width:0]   wr_ptr_bin,
    output logic [Addr_width:0]   wr_ptr_gray,
    output logic                  full,
    output logic [Addr_width:0]   level,
    output logic                  almost_full,
    output logic                  overflow
);
    if (Addr_width < 2 || Addr_width > 12) begin : g_bad_aw
        $error("wr_ptr_ctrl: Addr_width out of range 2..12");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > 2**Addr_width) begin : g_bad_th
        $error("wr_ptr_ctrl: AFULL_THRESH out of range 1..2**Addr_width");
    end
    logic [Addr_width:0] rd_bin, bin_next, gray_next, level_next;
    logic                full_next;
    assign wr_accept = Enable && !full;
    assign address   = wr_ptr_bin[Addr_width-1:0];
    always_comb begin
        rd_bin = '0;
        // Gray to binary: each bit is the XOR of itself and every higher Gray bit
        for (int i = 0; i <= Addr_width; i++) rd_bin[i] = ^(rd_ptr_gray_sync >> i);
        bin_next   = wr_ptr_bin + {{Addr_width{1'b0}}, wr_accept};
        gray_next  = bin_next ^ (bin_next >> 1);
        // In Gray space, "exactly one depth ahead" means the top two bits inverted
        full_next  = gray_next == {~rd_ptr_gray_sync[Addr_width:Addr_width-1], rd_ptr_gray_sync[Addr_width-2:0]};
        level_next = bin_next - rd_bin;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            level       <= '0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr_bin  <= bin_next;
            wr_ptr_gray <= gray_next;
            full        <= full_next;
            level       <= level_next;
            overflow    <= overflow | (Enable && full);
        end
    end
`ifdef WR_PTR_ALMOST_FULL_EN
    localparam int TW = Addr_width + 1;
    localparam logic [Addr_width:0] THRESH = TW'(AFULL_THRESH);
    always_ff @(posedge clk) begin
        almost_full <= rst ? 1'b0 : (level_next >= THRESH);
    end
`else
    assign almost_full = 1'b0;
`endif
endmodule
